// File: rtl/key_counter_with_disp.sv
// key_counter_with_disp: debounced active-low key advancing a BCD digit shown on a seven-segment display.
// Optional auto-repeat while the key is held is enabled by defining KEY_AUTO_REPEAT_EN.
module seven_segment_disp (
  input  logic [3:0] bcd,
  output logic [6:0] seg,
  output logic       n_segment
);
  always_comb begin
    seg = 7'h7f;
    case (bcd)
      4'd0: seg = 7'b1000000;
      4'd1: seg = 7'b1111001;
      4'd2: seg = 7'b0100100;
      4'd3: seg = 7'b0110000;
      4'd4: seg = 7'b0011001;
      4'd5: seg = 7'b0010010;
      4'd6: seg = 7'b0000010;
      4'd7: seg = 7'b1111000;
      4'd8: seg = 7'b0000000;
      4'd9: seg = 7'b0010000;
      default: seg = 7'h7f;
    endcase
  end
  assign n_segment = 1'b0;
endmodule

module key_counter_with_disp #(
  parameter int DEBOUNCE_CYCLES     = 1000000,
  parameter int REPEAT_DELAY_CYCLES = 25000000,
  parameter int REPEAT_RATE_CYCLES  = 5000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_n,
  output logic [3:0] count,
  output logic       press,
  output logic [6:0] seg,
  output logic       n_segment
);
  localparam int TW = $clog2(DEBOUNCE_CYCLES + 1);
  typedef enum logic [1:0] {IDLE, DEB_PRESS, HELD, DEB_RELEASE} state_t;
  state_t state_q, state_d;
  logic [1:0] sync_q;
  logic key_sync;
  logic [TW-1:0] tmr_q, tmr_d;
  logic [3:0] count_q, count_d;
  logic press_q, press_d;
  logic rep_fire;
  assign key_sync = sync_q[1];
  assign count_d = press_d ? (count_q == 4'd9 ? 4'd0 : count_q + 4'd1) : count_q;
`ifdef KEY_AUTO_REPEAT_EN
  localparam int RMAX = REPEAT_DELAY_CYCLES > REPEAT_RATE_CYCLES ? REPEAT_DELAY_CYCLES : REPEAT_RATE_CYCLES;
  localparam int RW = $clog2(RMAX + 1);
  logic [RW-1:0] rep_q, rep_d;
  logic first_q, first_d;
  // first_q selects the initial hold delay until the first repeat has fired
  assign rep_fire = state_q == HELD && rep_q == (first_q ? RW'(REPEAT_DELAY_CYCLES - 1) : RW'(REPEAT_RATE_CYCLES - 1));
  assign rep_d = (state_q == HELD && state_d == HELD && !rep_fire) ? rep_q + RW'(1) : '0;
  assign first_d = state_d != HELD ? 1'b1 : (rep_fire ? 1'b0 : first_q);
  always_ff @(posedge clk) begin
    if (rst) begin
      rep_q <= '0;
      first_q <= 1'b1;
    end else begin
      rep_q <= rep_d;
      first_q <= first_d;
    end
  end
`else
  logic unused_rep;
  assign rep_fire = 1'b0;
  assign unused_rep = REPEAT_DELAY_CYCLES[0] ^ REPEAT_RATE_CYCLES[0];
`endif
  always_comb begin
    state_d = state_q;
    tmr_d = tmr_q;
    press_d = 1'b0;
    case (state_q)
      IDLE: if (!key_sync) begin
        state_d = DEB_PRESS;
        tmr_d = '0;
      end
      DEB_PRESS: if (key_sync) state_d = IDLE;
        else if (tmr_q == TW'(DEBOUNCE_CYCLES - 1)) begin
          state_d = HELD;
          press_d = 1'b1;
        end else tmr_d = tmr_q + TW'(1);
      HELD: if (key_sync) begin
        state_d = DEB_RELEASE;
        tmr_d = '0;
      end else press_d = rep_fire;
      DEB_RELEASE: if (!key_sync) state_d = HELD;
        else if (tmr_q == TW'(DEBOUNCE_CYCLES - 1)) state_d = IDLE;
        else tmr_d = tmr_q + TW'(1);
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= 2'b11;
      state_q <= IDLE;
      tmr_q <= '0;
      count_q <= '0;
      press_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], key_n};
      state_q <= state_d;
      tmr_q <= tmr_d;
      count_q <= count_d;
      press_q <= press_d;
    end
  end
  assign count = count_q;
  assign press = press_q;
  seven_segment_disp u_disp (.bcd(count_q), .seg(seg), .n_segment(n_segment));
endmodule
